game_state_controller: RTL and testbench

//   Parametrised lives/level state machine for the Frogger top level. Replaces the two-state

---
 rtl/game_state_controller_pkg.sv | 29 ++
 rtl/game_state_controller_timer.sv | 31 +++
 rtl/game_state_controller.sv | 163 ++++++++++++++++
 tb/tb_game_state_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared state encodings, default parameter values and small helpers
// for the Frogger lives/level state machine.
package game_state_controller_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      RUNNING     = 3'd1,
      HIT         = 3'd2,
      LEVEL_PAUSE = 3'd3,
      GAME_OVER   = 3'd4
   } state_t;

   localparam int DEF_NUM_LIVES          = 4;
   localparam int DEF_INVULN_CYCLES      = 25_000_000;
   localparam int DEF_LEVEL_PAUSE_CYCLES = 12_500_000;
   localparam int DEF_MAX_LEVEL          = 15;

   // Larger of two integers, used to size the shared dwell timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Level increment that sticks at the ceiling instead of wrapping.
   function automatic logic [3:0] level_sat_inc(input logic [3:0] level,
                                                input logic [3:0] max_level);
      return (level >= max_level) ? level : level + 4'd1;
   endfunction

endpackage

// File: rtl/game_state_controller_timer.sv
// Loadable down-counter used for the HIT and LEVEL_PAUSE dwell times.
// Load has priority over decrement; the count holds at zero.
module game_timer
#(
   parameter int WIDTH = 8
)
(
   input  logic             i_Clk,
   input  logic             i_Rst_N,
   input  logic             i_Load,
   input  logic [WIDTH-1:0] i_Load_Value,
   input  logic             i_En,
   output logic             o_Zero
);

   logic [WIDTH-1:0] count_reg;

   // Count register: load a new dwell, otherwise count down toward zero.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         count_reg <= '0;
      end else if (i_Load) begin
         count_reg <= i_Load_Value;
      end else if (i_En && (count_reg != '0)) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign o_Zero = (count_reg == '0);

endmodule

// File: rtl/game_state_controller.sv
// Lives/level state machine for the Frogger top level: IDLE, RUNNING,
// post-hit invulnerability, level-up pause and a game-over hold.
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int NUM_LIVES          = DEF_NUM_LIVES,
   parameter int INVULN_CYCLES      = DEF_INVULN_CYCLES,
   parameter int LEVEL_PAUSE_CYCLES = DEF_LEVEL_PAUSE_CYCLES,
   parameter int MAX_LEVEL          = DEF_MAX_LEVEL,
   parameter int START_ALL          = 1
)
(
   input  logic                 i_Clk,
   input  logic                 i_Rst_N,
   input  logic                 i_Start_All,
   input  logic                 i_Start_Any,
   input  logic                 i_Has_Collided,
   input  logic                 i_Level_Up,
   output logic                 o_Game_Active,
   output logic                 o_Invulnerable,
   output logic                 o_Respawn,
   output logic                 o_Game_Over,
   output logic [NUM_LIVES-1:0] o_Lives,
   output logic [3:0]           o_Level,
   output logic [2:0]           o_State
);

   localparam int TIMER_MAX = max_int(INVULN_CYCLES, LEVEL_PAUSE_CYCLES);
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0]   INVULN_LOAD = TIMER_W'(INVULN_CYCLES - 1);
   localparam logic [TIMER_W-1:0]   PAUSE_LOAD  = TIMER_W'(LEVEL_PAUSE_CYCLES - 1);
   localparam logic [NUM_LIVES-1:0] LIVES_ONE   = NUM_LIVES'(1);
   localparam logic [3:0]           LEVEL_MAX   = 4'(MAX_LEVEL);

   state_t               state_reg, state_next;
   logic [NUM_LIVES-1:0] lives_reg, lives_next;
   logic [3:0]           level_reg, level_next;
   logic                 respawn_reg, respawn_next;
   logic                 game_active_reg;
   logic                 invulnerable_reg;
   logic                 game_over_reg;

   logic                 start;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_load_value;
   logic                 timer_en;
   logic                 timer_zero;

   assign start = (START_ALL != 0) ? i_Start_All : i_Start_Any;

   game_timer #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .i_Clk        (i_Clk),
      .i_Rst_N      (i_Rst_N),
      .i_Load       (timer_load),
      .i_Load_Value (timer_load_value),
      .i_En         (timer_en),
      .o_Zero       (timer_zero)
   );

   // Next-state, lives shifter, level counter and timer control.
   always_comb begin
      state_next       = state_reg;
      lives_next       = lives_reg;
      level_next       = level_reg;
      respawn_next     = 1'b0;
      timer_load       = 1'b0;
      timer_load_value = '0;
      timer_en         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUNNING;
               lives_next = '1;
               level_next = 4'd0;
            end
         end

         RUNNING: begin
            // A collision always beats a simultaneous level-up.
            if (i_Has_Collided) begin
               if (lives_reg == LIVES_ONE) begin
                  state_next = GAME_OVER;
                  lives_next = '0;
               end else begin
                  state_next       = HIT;
                  lives_next       = lives_reg >> 1;
                  respawn_next     = 1'b1;
                  timer_load       = 1'b1;
                  timer_load_value = INVULN_LOAD;
               end
            end else if (i_Level_Up) begin
               state_next       = LEVEL_PAUSE;
               level_next       = level_sat_inc(level_reg, LEVEL_MAX);
               timer_load       = 1'b1;
               timer_load_value = PAUSE_LOAD;
            end
         end

         HIT: begin
            // Collisions are ignored while invulnerable; level-ups still count.
            timer_en = 1'b1;
            if (i_Level_Up) begin
               level_next = level_sat_inc(level_reg, LEVEL_MAX);
            end
            if (timer_zero) begin
               state_next = RUNNING;
            end
         end

         LEVEL_PAUSE: begin
            timer_en = 1'b1;
            if (timer_zero) begin
               state_next = RUNNING;
            end
         end

         GAME_OVER: begin
            // Start must drop for a cycle so a held start cannot restart.
            if (!start) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; flags are decoded from the next state.
   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         state_reg        <= IDLE;
         lives_reg        <= '1;
         level_reg        <= 4'd0;
         respawn_reg      <= 1'b0;
         game_active_reg  <= 1'b0;
         invulnerable_reg <= 1'b0;
         game_over_reg    <= 1'b0;
      end else begin
         state_reg        <= state_next;
         lives_reg        <= lives_next;
         level_reg        <= level_next;
         respawn_reg      <= respawn_next;
         game_active_reg  <= (state_next == RUNNING) || (state_next == HIT);
         invulnerable_reg <= (state_next == HIT);
         game_over_reg    <= (state_next == GAME_OVER);
      end
   end

   assign o_State        = state_reg;
   assign o_Lives        = lives_reg;
   assign o_Level        = level_reg;
   assign o_Respawn      = respawn_reg;
   assign o_Game_Active  = game_active_reg;
   assign o_Invulnerable = invulnerable_reg;
   assign o_Game_Over    = game_over_reg;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench: each stimulus cycle queues the hand-computed outputs
// expected after the next edge; a negedge monitor pops and compares.
module tb_game_state_controller;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_HIT   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   typedef struct {
      int          cyc;
      logic [13:0] v;
      string       name;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start_all;
   logic       start_any;
   logic       has_collided;
   logic       level_up;
   logic       game_active;
   logic       invulnerable;
   logic       respawn;
   logic       game_over;
   logic [2:0] lives;
   logic [3:0] level;
   logic [2:0] state;

   int   cyc;
   int   errors;
   int   checks;
   exp_t exp_q[$];

   game_state_controller #(
      .NUM_LIVES          (3),
      .INVULN_CYCLES      (4),
      .LEVEL_PAUSE_CYCLES (3),
      .MAX_LEVEL          (2),
      .START_ALL          (1)
   ) dut (
      .i_Clk          (clk),
      .i_Rst_N        (rst_n),
      .i_Start_All    (start_all),
      .i_Start_Any    (start_any),
      .i_Has_Collided (has_collided),
      .i_Level_Up     (level_up),
      .o_Game_Active  (game_active),
      .o_Invulnerable (invulnerable),
      .o_Respawn      (respawn),
      .o_Game_Over    (game_over),
      .o_Lives        (lives),
      .o_Level        (level),
      .o_State        (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [13:0] mk(input logic [2:0] st, input logic [2:0] lv,
                                      input logic [3:0] lev, input logic act,
                                      input logic inv, input logic rsp, input logic go);
      return {st, lv, lev, act, inv, rsp, go};
   endfunction

   function automatic logic [13:0] actual();
      return {state, lives, level, game_active, invulnerable, respawn, game_over};
   endfunction

   // Monitor: compare the entry due this cycle against the DUT outputs.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks = checks + 1;
         if (e.cyc != cyc) begin
            errors = errors + 1;
            $display("FAIL %s: compared at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else if (actual() !== e.v) begin
            errors = errors + 1;
            $display("FAIL %s: got st=%0d lives=%b lvl=%0d act/inv/rsp/go=%b, required st=%0d lives=%b lvl=%0d act/inv/rsp/go=%b",
                     e.name, state, lives, level, actual()[3:0],
                     e.v[13:11], e.v[10:8], e.v[7:4], e.v[3:0]);
         end else begin
            $display("txn cyc=%0d %s: st=%0d lives=%b lvl=%0d act/inv/rsp/go=%b ok",
                     cyc, e.name, state, lives, level, actual()[3:0]);
         end
      end
   end

   // Drive one cycle of inputs and queue what the DUT must show after the edge.
   task automatic tick(input logic sa, input logic sy, input logic col, input logic lu,
                       input logic [13:0] ev, input string nm);
      exp_t e;
      start_all    = sa;
      start_any    = sy;
      has_collided = col;
      level_up     = lu;
      e.cyc  = cyc + 1;
      e.v    = ev;
      e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic direct_check(input logic [13:0] ev, input string nm);
      checks = checks + 1;
      if (actual() !== ev) begin
         errors = errors + 1;
         $display("FAIL %s: got %b, required %b", nm, actual(), ev);
      end else begin
         $display("txn %s: %b ok", nm, actual());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; errors = 0; checks = 0;
      rst_n = 1'b1; start_all = 1'b0; start_any = 1'b0;
      has_collided = 1'b0; level_up = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      direct_check(mk(S_IDLE, 3'b111, 4'd0, 0, 0, 0, 0), "reset_values");
      rst_n = 1'b1;

      // 1. start
      tick(1, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "start");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "running");

      // 2. collision held 10 cycles: hit, 4-cycle HIT, re-hit, 4-cycle HIT
      tick(0, 0, 1, 0, mk(S_HIT, 3'b011, 4'd0, 1, 1, 1, 0), "hit1");
      for (int i = 0; i < 3; i++)
         tick(0, 0, 1, 0, mk(S_HIT, 3'b011, 4'd0, 1, 1, 0, 0), "hit1_dwell");
      tick(0, 0, 1, 0, mk(S_RUN, 3'b011, 4'd0, 1, 0, 0, 0), "hit1_return");
      tick(0, 0, 1, 0, mk(S_HIT, 3'b001, 4'd0, 1, 1, 1, 0), "rehit");
      for (int i = 0; i < 3; i++)
         tick(0, 0, 1, 0, mk(S_HIT, 3'b001, 4'd0, 1, 1, 0, 0), "rehit_dwell");
      tick(0, 0, 1, 0, mk(S_RUN, 3'b001, 4'd0, 1, 0, 0, 0), "rehit_return");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b001, 4'd0, 1, 0, 0, 0), "clear");

      // 3. last life with start held, then release and restart
      tick(1, 0, 1, 0, mk(S_OVER, 3'b000, 4'd0, 0, 0, 0, 1), "game_over");
      tick(1, 0, 0, 0, mk(S_OVER, 3'b000, 4'd0, 0, 0, 0, 1), "over_held");
      tick(1, 0, 0, 0, mk(S_OVER, 3'b000, 4'd0, 0, 0, 0, 1), "over_held2");
      tick(0, 0, 0, 0, mk(S_IDLE, 3'b000, 4'd0, 0, 0, 0, 0), "over_release");
      tick(0, 1, 0, 0, mk(S_IDLE, 3'b000, 4'd0, 0, 0, 0, 0), "any_not_enough");
      tick(1, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "restart");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "restart_run");

      // 5. collision and level-up together: collision wins
      tick(0, 0, 1, 1, mk(S_HIT, 3'b011, 4'd0, 1, 1, 1, 0), "col_and_lvl");
      for (int i = 0; i < 3; i++)
         tick(0, 0, 0, 0, mk(S_HIT, 3'b011, 4'd0, 1, 1, 0, 0), "col_lvl_dwell");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b011, 4'd0, 1, 0, 0, 0), "col_lvl_return");

      // 4. three level-ups: 1, 2, 2; inputs ignored during the pause
      tick(0, 0, 0, 1, mk(S_PAUSE, 3'b011, 4'd1, 0, 0, 0, 0), "lvl1");
      tick(0, 0, 0, 0, mk(S_PAUSE, 3'b011, 4'd1, 0, 0, 0, 0), "lvl1_pause");
      tick(0, 0, 1, 1, mk(S_PAUSE, 3'b011, 4'd1, 0, 0, 0, 0), "lvl1_pause_ignore");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b011, 4'd1, 1, 0, 0, 0), "lvl1_return");
      tick(0, 0, 0, 1, mk(S_PAUSE, 3'b011, 4'd2, 0, 0, 0, 0), "lvl2");
      for (int i = 0; i < 2; i++)
         tick(0, 0, 0, 0, mk(S_PAUSE, 3'b011, 4'd2, 0, 0, 0, 0), "lvl2_pause");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b011, 4'd2, 1, 0, 0, 0), "lvl2_return");
      tick(0, 0, 0, 1, mk(S_PAUSE, 3'b011, 4'd2, 0, 0, 0, 0), "lvl_sat");
      for (int i = 0; i < 2; i++)
         tick(0, 0, 0, 0, mk(S_PAUSE, 3'b011, 4'd2, 0, 0, 0, 0), "lvl_sat_pause");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b011, 4'd2, 1, 0, 0, 0), "lvl_sat_return");

      // 6. enter HIT, level-up there stays saturated, then async reset mid-HIT
      tick(0, 0, 1, 0, mk(S_HIT, 3'b001, 4'd2, 1, 1, 1, 0), "hit_before_reset");
      tick(0, 0, 0, 1, mk(S_HIT, 3'b001, 4'd2, 1, 1, 0, 0), "hit_lvl_sat");
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      direct_check(mk(S_IDLE, 3'b111, 4'd0, 0, 0, 0, 0), "async_reset_mid_hit");
      rst_n = 1'b1;
      @(posedge clk); #1;
      tick(1, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "start_after_reset");
      tick(0, 0, 0, 0, mk(S_RUN, 3'b111, 4'd0, 1, 0, 0, 0), "run_after_reset");

      @(negedge clk); #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
